// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and default widths for the SDRAM arbiter
package sdram_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ_VIDEO = 1'b0;
  localparam req_id_t REQ_CPU   = 1'b1;

  localparam int DEF_ADDR_W          = 24;
  localparam int DEF_DATA_W          = 16;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_STARVE_LIMIT    = 16;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// rtl/sdram_arb_tag_fifo.sv - in-order requester-ID FIFO for outstanding reads
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t pop_id,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  req_id_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_id  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port Avalon-MM arbiter in front of the SDRAM controller
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     r0_address,
  input  logic                  r0_read,
  input  logic                  r0_write,
  input  logic [DATA_W-1:0]     r0_writedata,
  input  logic [DATA_W/8-1:0]   r0_byteenable,
  output logic                  r0_waitrequest,
  output logic [DATA_W-1:0]     r0_readdata,
  output logic                  r0_readdatavalid,
  input  logic [ADDR_W-1:0]     r1_address,
  input  logic                  r1_read,
  input  logic                  r1_write,
  input  logic [DATA_W-1:0]     r1_writedata,
  input  logic [DATA_W/8-1:0]   r1_byteenable,
  output logic                  r1_waitrequest,
  output logic [DATA_W-1:0]     r1_readdata,
  output logic                  r1_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  output logic                  err_rdv
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                 fifo_full;
  logic                 fifo_empty;
  req_id_t              pop_id;
  logic                 slot_free;
  logic                 cand0;
  logic                 cand1;
  logic                 starved;
  logic                 grant0;
  logic                 grant1;
  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     starve_cnt;
  logic [ADDR_W-1:0]    sel_address;
  logic [DATA_W-1:0]    sel_writedata;
  logic [DATA_W/8-1:0]  sel_byteenable;
  logic                 sel_read;
  logic                 sel_write;

  assign slot_free = !(m_read || m_write) || !m_waitrequest;
  assign cand0     = r0_write || (r0_read && !fifo_full);
  assign cand1     = r1_write || (r1_read && !fifo_full);
  assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant1    = slot_free && cand1 && (starved || !cand0);
  assign grant0    = slot_free && cand0 && !grant1;

  // Reset gating keeps both masters stalled while the core is held in reset.
  assign r0_waitrequest = !(grant0 && reset_reset_n);
  assign r1_waitrequest = !(grant1 && reset_reset_n);

  assign push = (grant0 && r0_read) || (grant1 && r1_read);
  assign pop  = m_readdatavalid && !fifo_empty;

  always_comb begin
    sel_address    = r0_address;
    sel_writedata  = r0_writedata;
    sel_byteenable = r0_byteenable;
    sel_read       = r0_read;
    sel_write      = r0_write;
    if (grant1) begin
      sel_address    = r1_address;
      sel_writedata  = r1_writedata;
      sel_byteenable = r1_byteenable;
      sel_read       = r1_read;
      sel_write      = r1_write;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else if (slot_free) begin
      m_read  <= (grant0 || grant1) && sel_read;
      m_write <= (grant0 || grant1) && sel_write;
      if (grant0 || grant1) begin
        m_address    <= sel_address;
        m_writedata  <= sel_writedata;
        m_byteenable <= sel_byteenable;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      starve_cnt <= '0;
    end else if (grant1 || !(r1_read || r1_write)) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (push),
    .push_id (grant1 ? REQ_CPU : REQ_VIDEO),
    .pop     (pop),
    .pop_id  (pop_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Data arriving with nothing outstanding is dropped and flagged.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r0_readdata      <= '0;
      r1_readdata      <= '0;
      r0_readdatavalid <= 1'b0;
      r1_readdatavalid <= 1'b0;
      err_rdv          <= 1'b0;
    end else begin
      r0_readdatavalid <= pop && (pop_id == REQ_VIDEO);
      r1_readdatavalid <= pop && (pop_id == REQ_CPU);
      if (pop) begin
        r0_readdata <= m_readdata;
        r1_readdata <= m_readdata;
      end
      if (m_readdatavalid && fifo_empty) err_rdv <= 1'b1;
    end
  end

endmodule
